// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable wait states and fault flagging.
// Define DMEM_IOREG_EN to add the byte-wide memory-mapped I/O register (port IoOut) at 0xFFFF_FFFC.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Ready,
    output logic [31:0] RData,
`ifdef DMEM_IOREG_EN
    output logic [7:0]  IoOut,
`endif
    output logic        Err
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        we_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;

    logic [31:0] mem [DEPTH_WORDS];

    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [31:0]      acc_off;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_io;
    logic             acc_fault;
    logic             commit;
    logic [31:0]      load_data;

    // Unsigned offset: addresses below BASE_ADDR wrap to huge values and land out of range.
    function automatic logic addr_fault(input logic [1:0] low_bits, input logic [31:0] off);
        return (low_bits != 2'b00) || (off >= SPAN);
    endfunction

    // With zero wait states the access happens on the acceptance edge, so the live inputs are used.
    always_comb begin
        acc_we    = we_p0;
        acc_addr  = addr_p0;
        acc_wdata = wdata_p0;
        if (state == IDLE) begin
            acc_we    = WE;
            acc_addr  = Addr;
            acc_wdata = WData;
        end
    end

    assign acc_off   = acc_addr - BASE_ADDR;
    assign acc_idx   = acc_off[IDX_W+1:2];
    assign acc_fault = !acc_io && addr_fault(acc_addr[1:0], acc_off);
    assign commit    = Reset && (((state == IDLE) && Req && (WAIT_CYCLES == 0)) ||
                                 ((state == WAIT) && (wait_cnt == 4'd1)));

`ifdef DMEM_IOREG_EN
    localparam logic [31:0] IO_ADDR = 32'hFFFF_FFFC;

    assign acc_io    = (acc_addr == IO_ADDR);
    assign load_data = acc_io ? {24'h0, IoOut} : mem[acc_idx];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            IoOut <= 8'h00;
        end else if (commit && acc_io && acc_we) begin
            IoOut <= acc_wdata[7:0];
        end
    end
`else
    assign acc_io    = 1'b0;
    assign load_data = mem[acc_idx];
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            we_p0    <= 1'b0;
            addr_p0  <= 32'h0;
            wdata_p0 <= 32'h0;
            Ready    <= 1'b0;
            Err      <= 1'b0;
            RData    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req) begin
                        we_p0    <= WE;
                        addr_p0  <= Addr;
                        wdata_p0 <= WData;
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Outputs are only non-zero in the cycle after the committing edge.
            if (commit) begin
                Ready <= 1'b1;
                Err   <= acc_fault;
                RData <= (acc_fault || acc_we) ? 32'h0 : load_data;
            end else begin
                Ready <= 1'b0;
                Err   <= 1'b0;
                RData <= 32'h0;
            end
        end
    end

    // Storage is never reset; a store only lands on its committing edge.
    always_ff @(posedge Clk) begin
        if (commit && acc_we && !acc_fault && !acc_io) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 0 and 3 wait states) driven with directed and random
// transactions, each response compared against a word-array model of the storage.
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int N     = 3;
    localparam int DEPTH = 64;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic        req   [N];
    logic        we    [N];
    logic [31:0] addr  [N];
    logic [31:0] wdata [N];
    logic        ready [N];
    logic [31:0] rdata [N];
    logic        err   [N];
`ifdef DMEM_IOREG_EN
    logic [7:0]  io_out [N];
`endif

    logic [31:0] mdl    [N][DEPTH];
    logic [7:0]  mdl_io [N];
    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .BASE_ADDR  (32'h0000_0000),
            .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)
        ) dut (
            .Clk  (Clk),
            .Reset(Reset),
            .Req  (req[g]),
            .WE   (we[g]),
            .Addr (addr[g]),
            .WData(wdata[g]),
            .Ready(ready[g]),
            .RData(rdata[g]),
`ifdef DMEM_IOREG_EN
            .IoOut(io_out[g]),
`endif
            .Err  (err[g])
        );
    end

    function automatic int wc(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    function automatic bit mdl_is_io(input logic [31:0] a);
`ifdef DMEM_IOREG_EN
        return a == 32'hFFFF_FFFC;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit mdl_fault(input logic [31:0] a);
        if (mdl_is_io(a)) return 1'b0;
        return ((a % 4) != 0) || (a >= DEPTH * 4);
    endfunction

    // One full transaction on instance k; model updated from the accepted values only.
    task automatic do_txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit scramble, input string tag);
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          got;
        int          lat;
        @(negedge Clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        exp_err = mdl_fault(a);
        exp_rd  = 32'h0;
        if (!exp_err && !w) exp_rd = mdl_is_io(a) ? {24'h0, mdl_io[k]} : mdl[k][a[7:2]];
        if (!exp_err && w) begin
            if (mdl_is_io(a)) mdl_io[k] = d[7:0];
            else mdl[k][a[7:2]] = d;
        end
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 24 && !got; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                req[k] = 1'b0;
                if (scramble) begin
                    we[k] = 1'($urandom_range(0, 1)); addr[k] = $urandom; wdata[k] = $urandom;
                end
            end
            if (ready[k] === 1'b1) begin got = 1'b1; lat = c; end
        end
        checks++;
        if (!got || lat != wc(k) + 1) begin
            errors++;
            $display("FAIL %s latency inst%0d: got %0d cycles (seen=%0d), want %0d", tag, k, lat, got, wc(k) + 1);
        end
        checks++;
        if (err[k] !== exp_err) begin
            errors++;
            $display("FAIL %s err inst%0d addr=%h: got %b, want %b", tag, k, a, err[k], exp_err);
        end
        checks++;
        if (rdata[k] !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata inst%0d addr=%h: got %h, want %h", tag, k, a, rdata[k], exp_rd);
        end
`ifdef DMEM_IOREG_EN
        if (w && mdl_is_io(a)) begin
            checks++;
            if (io_out[k] !== mdl_io[k]) begin
                errors++;
                $display("FAIL %s io_out inst%0d: got %h, want %h", tag, k, io_out[k], mdl_io[k]);
            end
        end
`endif
        @(negedge Clk);
        checks++;
        if (ready[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'h0) begin
            errors++;
            $display("FAIL %s idle_after inst%0d: ready=%b err=%b rdata=%h, want 0/0/0", tag, k, ready[k], err[k], rdata[k]);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        for (int k = 0; k < N; k++) mdl_io[k] = 8'h00;
        repeat (3) @(negedge Clk);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ready[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: ready=%b err=%b rdata=%h, want 0/0/0", k, ready[k], err[k], rdata[k]);
            end
`ifdef DMEM_IOREG_EN
            checks++;
            if (io_out[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_io inst%0d: got %h, want 00", k, io_out[k]);
            end
`endif
        end
        Reset = 1'b1;
    endtask

    task automatic preload();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < DEPTH; i++) do_txn(k, 1'b1, 32'(i * 4), $urandom, 1'b0, "preload");
    endtask

    task automatic test_store_load();
        do_txn(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, "store8");
        do_txn(0, 1'b0, 32'h8, 32'h0, 1'b0, "load8");
    endtask

    // Req stays high on the zero-wait instance: one Ready every second cycle.
    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] exp_rd;
        @(negedge Clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'($urandom_range(0, DEPTH - 1) * 4);
        for (int i = 0; i < 8; i++) begin
            a = addr[1];
            exp_rd = mdl[1][a[7:2]];
            @(negedge Clk);
            checks++;
            if (ready[1] !== 1'b1 || err[1] !== 1'b0 || rdata[1] !== exp_rd) begin
                errors++;
                $display("FAIL b2b_resp %0d addr=%h: ready=%b err=%b rdata=%h, want 1/0/%h", i, a, ready[1], err[1], rdata[1], exp_rd);
            end
            if (i < 7) addr[1] = 32'($urandom_range(0, DEPTH - 1) * 4);
            else req[1] = 1'b0;
            @(negedge Clk);
            checks++;
            if (ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap %0d: ready=%b, want 0", i, ready[1]);
            end
        end
    endtask

    task automatic test_fault();
        do_txn(0, 1'b0, 32'h6, 32'h0, 1'b0, "misaligned_ld");
        do_txn(0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, "store0");
        do_txn(0, 1'b1, 32'h100, 32'hBAD0_BAD0, 1'b0, "oor_store");
        do_txn(0, 1'b0, 32'h0, 32'h0, 1'b0, "load0_after_oor");
        do_txn(0, 1'b1, 32'hFC, 32'hCAFE_F00D, 1'b0, "store_last");
        do_txn(0, 1'b0, 32'hFC, 32'h0, 1'b0, "load_last");
        do_txn(2, 1'b1, 32'h102, 32'h1111_2222, 1'b0, "mis_oor_store");
        do_txn(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, "top_word_ld");
    endtask

    task automatic test_latch();
        logic [31:0] a;
        for (int k = 0; k < N; k++) begin
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
            do_txn(k, 1'b1, a, $urandom, 1'b1, "latch_store");
            do_txn(k, 1'b0, a, 32'h0, 1'b1, "latch_load");
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_txn(2, 1'b1, 32'h10, 32'hA1A2_A3A4, 1'b0, "pre10");
        @(negedge Clk);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h10; wdata[2] = 32'h5555_AAAA;
        @(negedge Clk);
        req[2] = 1'b0;
        Reset = 1'b0;
        for (int k = 0; k < N; k++) mdl_io[k] = 8'h00;
        pulses = 0;
        repeat (4) begin
            @(negedge Clk);
            if (ready[2] !== 1'b0) pulses++;
        end
        Reset = 1'b1;
        repeat (6) begin
            @(negedge Clk);
            if (ready[2] !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_ready: %0d Ready pulses, want 0", pulses);
        end
        do_txn(2, 1'b0, 32'h10, 32'h0, 1'b0, "reset_mid_load10");
        do_txn(2, 1'b1, 32'h14, 32'h0F0F_0F0F, 1'b0, "reset_mid_next_st");
        do_txn(2, 1'b0, 32'h14, 32'h0, 1'b0, "reset_mid_next_ld");
    endtask

`ifdef DMEM_IOREG_EN
    task automatic test_ioreg();
        do_txn(0, 1'b1, 32'hFFFF_FFFC, 32'h0000_00A5, 1'b0, "io_store");
        do_txn(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, "io_load");
        do_txn(2, 1'b1, 32'hFFFF_FFFC, 32'h1234_565A, 1'b1, "io_store_w3");
        do_txn(2, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, "io_load_w3");
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        int          sel;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 25; i++) begin
                sel = $urandom_range(0, 9);
                if (sel <= 6)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
                else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                else if (sel == 8) a = 32'(DEPTH * 4 + $urandom_range(0, 1000) * 4);
                else               a = 32'hFFFF_FF00 | 32'($urandom_range(0, 63) * 4);
                do_txn(k, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), "random");
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0; mdl_io[k] = 8'h00;
        end
        test_reset();
        preload();
        test_store_load();
        test_back_to_back();
        test_fault();
        test_latch();
        test_reset_mid();
`ifdef DMEM_IOREG_EN
        test_ioreg();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the processor's load/store interface.
- Accepts one request at a time: address, write-enable and write data.
- Holds word storage internally and returns read data with a one-cycle Ready pulse after a programmable number of wait states.
- Flags misaligned or out-of-range accesses with Err instead of touching memory.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words stored (power of two, 4..4096)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4
WAIT_CYCLES, 1, wait states between acceptance and response (0..15)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous active-low reset (0 = reset asserted)
Req  in  1  request valid
WE  in  1  1 = store, 0 = load; sampled with Req
Addr  in  32  byte address; sampled with Req
WData  in  32  store data; sampled with Req
Ready  out  1  single-cycle response strobe
RData  out  32  load data; valid while Ready=1
Err  out  1  access fault; valid while Ready=1

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low.
- Reset values: state=IDLE, wait counter=0, Ready=0, Err=0, RData=0, latched request cleared. Memory array is NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Req=1 at a rising edge means acceptance.
  - Latch WE, Addr and WData; load counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - Req=0: stay in IDLE.
- WAIT:
  - Decrement counter each edge.
  - When counter reaches 1, go to RESP on that edge.
  - Req ignored.
- RESP:
  - Ready=1 for exactly one cycle; always go to IDLE next.
  - A Req held high is accepted at the first IDLE edge afterwards.
  - Minimum issue interval is WAIT_CYCLES+2 cycles.
- Latency: Ready is high in the cycle WAIT_CYCLES+1 cycles after the acceptance cycle.
- Latched inputs: only the acceptance-cycle values matter. Later changes to Addr, WE or WData, or dropping Req, have no effect on the transaction in flight.
- Decode: offset = latched Addr - BASE_ADDR.
  - Fault if latched Addr[1:0] != 0, or if offset >= DEPTH_WORDS*4 (unsigned, so addresses below BASE_ADDR wrap and also fault).
  - Word index = offset[log2(DEPTH_WORDS)+1:2].
- Store:
  - Memory write commits on the edge entering RESP.
  - RData=0 during RESP.
  - A load issued next sees the new value.
- Load: RData is registered on the edge entering RESP and holds the addressed word.
- Fault:
  - Ready=1 and Err=1 in RESP.
  - No memory write; RData=0.
- Outside RESP: Ready=0, Err=0, RData=0.
- Reset mid-transaction: return to IDLE immediately with all outputs 0.
  - An uncommitted store (reset before the RESP-entry edge) is discarded.
  - Memory contents are preserved.

Optional Feature:
- Macro: DMEM_IOREG_EN.
- Defined:
  - Adds output port IoOut [7:0], reset value 8'h00.
  - Word address 32'hFFFF_FFFC is a memory-mapped I/O register, decoded before the range check and never faulting.
  - Store: IoOut <= WData[7:0] on the RESP-entry edge.
  - Load: RData = {24'b0, IoOut}.
  - Same FSM and latency as memory.
- Not defined: no IoOut port; 32'hFFFF_FFFC decodes like any other address (fault unless inside range).

Test Plan:
- Reset, defaults (WAIT_CYCLES=1): store WE=1, Addr=0x8, WData=0xDEADBEEF; then load Addr=0x8 -> both Ready 2 cycles after acceptance, Err=0; load returns RData=0xDEADBEEF.
- WAIT_CYCLES=0: back-to-back loads with Req held high -> Ready every 2nd cycle, RData matches each preloaded word.
- Misaligned address: load Addr=0x6 -> Ready=1, Err=1, RData=0. Out-of-range store to Addr=0x100 (DEPTH_WORDS=64) -> Err=1, and a later load of 0x0 returns its prior value.
- Input changes after acceptance: change Addr/WData and drop Req the cycle after acceptance -> response reflects the accepted values only.
- Reset mid-operation: assert Reset during WAIT of a store to 0x10 (WAIT_CYCLES=3) -> Ready never pulses, 0x10 unchanged, and the next transaction completes normally.
- With DMEM_IOREG_EN: store 0x000000A5 to 0xFFFFFFFC -> IoOut=8'hA5; load from 0xFFFFFFFC -> RData=0x000000A5, Err=0.
